// File: rtl/apb_pkg.sv
// Shared types and constants for the APB register responder.
package apb_pkg;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } apb_state_e;

  localparam int          WAIT_W        = 4;
  localparam logic [31:0] OFS_ID        = 32'h0000_0000;
  localparam logic [31:0] OFS_SCRATCH   = 32'h0000_0004;
  localparam logic [31:0] OFS_DATA_BASE = 32'h0000_0008;
  localparam logic [31:0] DEFAULT_ID    = 32'h1234_5678;

endpackage

// File: rtl/apb_wait_timer.sv
// Loadable down-counter that paces the pready-low access cycles.
module apb_wait_timer
  import apb_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              en,
  input  logic [WAIT_W-1:0] load_val,
  output logic              zero
);

  logic [WAIT_W-1:0] cnt_q, cnt_d;

  // Next count: load wins, otherwise step down and stop at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (en && (cnt_q != '0)) begin
      cnt_d = cnt_q - WAIT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/apb_reg_responder.sv
// APB3 completer with ID, scratch/data registers and a transfer counter,
// programmable wait states and error response.
module apb_reg_responder
  import apb_pkg::*;
#(
  parameter int          NUM_REGS    = 8,
  parameter int          WAIT_CYCLES = 1,
  parameter logic [31:0] ID_VALUE    = DEFAULT_ID
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] paddr,
  input  logic [31:0] pwdata,
  input  logic        pwrite,
  input  logic        psel,
  input  logic        penable,
  output logic        pready,
  output logic [31:0] prdata,
  output logic        pslverr
);

  localparam int          IDX_W   = $clog2(NUM_REGS);
  localparam logic [31:0] CNT_OFS = 32'((NUM_REGS - 1) * 4);
  localparam logic [31:0] END_OFS = 32'(NUM_REGS * 4);
  // The timer counts down to zero and pready is raised on the zero cycle,
  // so it is preloaded one short of the wait count.
  localparam logic [WAIT_W-1:0] WAIT_LOAD =
    (WAIT_CYCLES == 0) ? '0 : WAIT_W'(WAIT_CYCLES - 1);

  apb_state_e  state_q, state_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, prdata_q, prdata_d;
  logic [31:0] xfer_cnt_q, xfer_cnt_d;
  logic        wr_q, wr_d, pready_q, pready_d, pslverr_q, pslverr_d;
  logic [31:0] rw_q [NUM_REGS];
  logic [31:0] rw_d [NUM_REGS];

  logic [31:0]      dec_addr, resp_rdata;
  logic             dec_wr, resp_err, wr_en;
  logic             tmr_load, tmr_en, tmr_zero;
  logic [IDX_W-1:0] dec_idx, wr_idx;

  apb_wait_timer u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .en       (tmr_en),
    .load_val (WAIT_LOAD),
    .zero     (tmr_zero)
  );

  // Decode the live bus during setup (zero-wait response), captured copy after.
  always_comb begin
    dec_addr = addr_q;
    dec_wr   = wr_q;
    if (state_q == ST_IDLE) begin
      dec_addr = paddr;
      dec_wr   = pwrite;
    end else begin
      dec_addr = addr_q;
      dec_wr   = wr_q;
    end
  end

  assign dec_idx = dec_addr[IDX_W+1:2];
  assign wr_idx  = addr_q[IDX_W+1:2];

  always_comb begin
    resp_err = (dec_addr >= END_OFS) || (dec_addr[1:0] != 2'b00) ||
               (dec_wr && ((dec_addr == OFS_ID) || (dec_addr == CNT_OFS)));
    resp_rdata = 32'd0;
    if (resp_err || dec_wr) begin
      resp_rdata = 32'd0;
    end else if (dec_addr == OFS_ID) begin
      resp_rdata = ID_VALUE;
    end else if (dec_addr == CNT_OFS) begin
      resp_rdata = xfer_cnt_q;
    end else if ((dec_addr == OFS_SCRATCH) || (dec_addr >= OFS_DATA_BASE)) begin
      resp_rdata = rw_q[dec_idx];
    end else begin
      resp_rdata = 32'd0;
    end
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wr_d       = wr_q;
    wdata_d    = wdata_q;
    pready_d   = pready_q;
    prdata_d   = prdata_q;
    pslverr_d  = pslverr_q;
    xfer_cnt_d = xfer_cnt_q;
    wr_en      = 1'b0;
    tmr_load   = 1'b0;
    tmr_en     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (psel && !penable) begin
          addr_d   = paddr;
          wr_d     = pwrite;
          wdata_d  = pwdata;
          tmr_load = 1'b1;
          state_d  = ST_ACCESS;
          if (WAIT_CYCLES == 0) begin
            pready_d  = 1'b1;
            prdata_d  = resp_rdata;
            pslverr_d = resp_err;
          end else begin
            pready_d  = 1'b0;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACCESS: begin
        if (!psel) begin
          state_d   = ST_IDLE;
          pready_d  = 1'b0;
          prdata_d  = 32'd0;
          pslverr_d = 1'b0;
        end else if (penable && pready_q) begin
          wr_en      = wr_q && !pslverr_q;
          xfer_cnt_d = xfer_cnt_q + 32'd1;
          state_d    = ST_IDLE;
          pready_d   = 1'b0;
          prdata_d   = 32'd0;
          pslverr_d  = 1'b0;
        end else if (penable) begin
          if (tmr_zero) begin
            pready_d  = 1'b1;
            prdata_d  = resp_rdata;
            pslverr_d = resp_err;
          end else begin
            tmr_en = 1'b1;
          end
        end else begin
          state_d = ST_ACCESS;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        pready_d  = 1'b0;
        prdata_d  = 32'd0;
        pslverr_d = 1'b0;
      end
    endcase
  end

  // Register bank next state; errored writes never reach here.
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      rw_d[i] = rw_q[i];
    end
    if (wr_en) begin
      rw_d[wr_idx] = wdata_q;
    end else begin
      rw_d[wr_idx] = rw_q[wr_idx];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      addr_q     <= 32'd0;
      wr_q       <= 1'b0;
      wdata_q    <= 32'd0;
      pready_q   <= 1'b0;
      prdata_q   <= 32'd0;
      pslverr_q  <= 1'b0;
      xfer_cnt_q <= 32'd0;
      for (int i = 0; i < NUM_REGS; i++) begin
        rw_q[i] <= 32'd0;
      end
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wr_q       <= wr_d;
      wdata_q    <= wdata_d;
      pready_q   <= pready_d;
      prdata_q   <= prdata_d;
      pslverr_q  <= pslverr_d;
      xfer_cnt_q <= xfer_cnt_d;
      for (int i = 0; i < NUM_REGS; i++) begin
        rw_q[i] <= rw_d[i];
      end
    end
  end

  assign pready  = pready_q;
  assign prdata  = prdata_q;
  assign pslverr = pslverr_q;

endmodule

// File: tb/tb_apb_reg_responder.sv
// Directed bench for apb_reg_responder: a vector table on a one-wait instance
// plus hand sequences for abort, reset, counter wrap and zero/three waits.
module tb_apb_reg_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] paddr = 32'd0;
  logic [31:0] pwdata = 32'd0;
  logic        pwrite = 1'b0;
  logic        penable = 1'b0;
  logic [2:0]  psel_v = 3'b000;
  logic        pready_a [3];
  logic [31:0] prdata_a [3];
  logic        pslverr_a [3];

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  apb_reg_responder #(.NUM_REGS(8), .WAIT_CYCLES(1)) u_w1 (
    .clk(clk), .rst(rst), .paddr(paddr), .pwdata(pwdata), .pwrite(pwrite),
    .psel(psel_v[0]), .penable(penable),
    .pready(pready_a[0]), .prdata(prdata_a[0]), .pslverr(pslverr_a[0]));

  apb_reg_responder #(.NUM_REGS(8), .WAIT_CYCLES(0)) u_w0 (
    .clk(clk), .rst(rst), .paddr(paddr), .pwdata(pwdata), .pwrite(pwrite),
    .psel(psel_v[1]), .penable(penable),
    .pready(pready_a[1]), .prdata(prdata_a[1]), .pslverr(pslverr_a[1]));

  apb_reg_responder #(.NUM_REGS(8), .WAIT_CYCLES(3)) u_w3 (
    .clk(clk), .rst(rst), .paddr(paddr), .pwdata(pwdata), .pwrite(pwrite),
    .psel(psel_v[2]), .penable(penable),
    .pready(pready_a[2]), .prdata(prdata_a[2]), .pslverr(pslverr_a[2]));

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
  } vec_t;

  vec_t vt [13];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // One full transfer on instance k; the bus is scrambled during access so
  // only the captured setup values may matter.
  task automatic xfer(input int k, input logic wr, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [31:0] exp_rd,
                      input logic exp_err, input int exp_wait, input string nm);
    bit seen;
    seen = 1'b0;
    psel_v = 3'b000;
    psel_v[k] = 1'b1;
    penable = 1'b0;
    pwrite = wr;
    paddr = addr;
    pwdata = wdata;
    @(posedge clk); #1;
    penable = 1'b1;
    paddr = ~addr;
    pwdata = ~wdata;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      if (pready_a[k]) begin
        seen = 1'b1;
        chk({nm, " wait"}, 32'(c), 32'(exp_wait));
        chk({nm, " rdata"}, prdata_a[k], exp_rd);
        chk({nm, " err"}, {31'd0, pslverr_a[k]}, {31'd0, exp_err});
      end
      @(posedge clk); #1;
    end
    if (!seen) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s timeout: pready never rose", nm);
    end
    psel_v = 3'b000;
    penable = 1'b0;
    chk({nm, " pready drop"}, {31'd0, pready_a[k]}, 32'd0);
  endtask

  initial begin
    vt[0]  = '{1'b0, 32'h0000_0000, 32'h0,         32'h1234_5678, 1'b0};
    vt[1]  = '{1'b1, 32'h0000_0004, 32'hDEAD_BEEF, 32'h0,         1'b0};
    vt[2]  = '{1'b0, 32'h0000_0004, 32'h0,         32'hDEAD_BEEF, 1'b0};
    vt[3]  = '{1'b1, 32'h0000_0000, 32'h0BAD_0BAD, 32'h0,         1'b1};
    vt[4]  = '{1'b0, 32'h0000_0020, 32'h0,         32'h0,         1'b1};
    vt[5]  = '{1'b0, 32'h0000_0005, 32'h0,         32'h0,         1'b1};
    vt[6]  = '{1'b0, 32'h0000_0000, 32'h0,         32'h1234_5678, 1'b0};
    vt[7]  = '{1'b1, 32'h0000_0008, 32'hCAFE_F00D, 32'h0,         1'b0};
    vt[8]  = '{1'b1, 32'h0000_0018, 32'h1122_3344, 32'h0,         1'b0};
    vt[9]  = '{1'b1, 32'h0000_001C, 32'h0000_0099, 32'h0,         1'b1};
    vt[10] = '{1'b0, 32'h0000_0008, 32'h0,         32'hCAFE_F00D, 1'b0};
    vt[11] = '{1'b0, 32'h0000_0018, 32'h0,         32'h1122_3344, 1'b0};
    vt[12] = '{1'b0, 32'h0000_001C, 32'h0,         32'd12,        1'b0};

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset pready", {31'd0, pready_a[0]}, 32'd0);
    chk("reset prdata", prdata_a[0], 32'd0);
    chk("reset pslverr", {31'd0, pslverr_a[0]}, 32'd0);
    @(posedge clk); #1;

    for (int i = 0; i < 13; i++) begin
      xfer(0, vt[i].wr, vt[i].addr, vt[i].wdata, vt[i].rdata, vt[i].err, 1,
           $sformatf("vec%0d", i));
    end

    // Counter wrap: hold the count at all-ones across an idle edge.
    force u_w1.xfer_cnt_q = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    release u_w1.xfer_cnt_q;
    xfer(0, 1'b0, 32'h1C, 32'h0, 32'hFFFF_FFFF, 1'b0, 1, "cnt max");
    xfer(0, 1'b0, 32'h1C, 32'h0, 32'h0, 1'b0, 1, "cnt wrap");

    // Reset while pready is high on an ID read.
    psel_v = 3'b001; pwrite = 1'b0; paddr = 32'h0; penable = 1'b0;
    @(posedge clk); #1;
    penable = 1'b1;
    @(posedge clk); #1;
    chk("pre-rst pready", {31'd0, pready_a[0]}, 32'd1);
    chk("pre-rst prdata", prdata_a[0], 32'h1234_5678);
    rst = 1'b1;
    #1;
    chk("mid-rst pready", {31'd0, pready_a[0]}, 32'd0);
    chk("mid-rst prdata", prdata_a[0], 32'd0);
    chk("mid-rst pslverr", {31'd0, pslverr_a[0]}, 32'd0);
    psel_v = 3'b000; penable = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;

    xfer(0, 1'b0, 32'h04, 32'h0, 32'h0, 1'b0, 1, "post-rst scratch");
    xfer(0, 1'b0, 32'h08, 32'h0, 32'h0, 1'b0, 1, "post-rst data");

    // Abort a write to 0x08 by dropping psel in the first access cycle.
    psel_v = 3'b001; pwrite = 1'b1; paddr = 32'h08; pwdata = 32'h5555_5555; penable = 1'b0;
    @(posedge clk); #1;
    psel_v = 3'b000;
    @(negedge clk);
    chk("abort pready", {31'd0, pready_a[0]}, 32'd0);
    @(posedge clk); #1;

    // psel+penable without a setup phase must be ignored.
    psel_v = 3'b001; penable = 1'b1; pwrite = 1'b0; paddr = 32'h0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk($sformatf("no-setup pready%0d", i), {31'd0, pready_a[0]}, 32'd0);
    end
    @(posedge clk); #1;
    psel_v = 3'b000; penable = 1'b0;
    @(posedge clk); #1;

    xfer(0, 1'b0, 32'h08, 32'h0, 32'h0, 1'b0, 1, "abort data kept");
    xfer(0, 1'b0, 32'h10, 32'h0, 32'h0, 1'b0, 1, "read 0x10");
    xfer(0, 1'b0, 32'h14, 32'h0, 32'h0, 1'b0, 1, "read 0x14");
    xfer(0, 1'b0, 32'h1C, 32'h0, 32'd5, 1'b0, 1, "cnt five");

    xfer(1, 1'b0, 32'h00, 32'h0, 32'h1234_5678, 1'b0, 0, "w0 id");
    xfer(1, 1'b1, 32'h04, 32'hA5A5_A5A5, 32'h0, 1'b0, 0, "w0 write");
    xfer(1, 1'b0, 32'h04, 32'h0, 32'hA5A5_A5A5, 1'b0, 0, "w0 readback");

    xfer(2, 1'b0, 32'h00, 32'h0, 32'h1234_5678, 1'b0, 3, "w3 id");
    xfer(2, 1'b0, 32'h20, 32'h0, 32'h0, 1'b1, 3, "w3 range err");
    xfer(2, 1'b0, 32'h1C, 32'h0, 32'd2, 1'b0, 3, "w3 cnt");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
